// File: rtl/reg_scan_checker_if.sv
// Bus between the CPU test wrapper and reg_scan_checker: run control, regfile port A, expected memory, results.
// FAIL_CAPTURE_EN adds the first-failure capture signals.
interface reg_scan_checker_if #(
  parameter int unsigned CYC_W = 10
);
  logic             start;
  logic             rwe;
  logic [4:0]       rd;
  logic [4:0]       rs1_cpu;
  logic [4:0]       rs1_out;
  logic [31:0]      regA;
  logic [4:0]       exp_addr;
  logic [31:0]      exp_data;
  logic             test_mode;
  logic             busy;
  logic             done;
  logic             pass;
  logic [5:0]       err_count;
  logic [15:0]      write_count;
  logic [CYC_W-1:0] cycle_count;
`ifdef FAIL_CAPTURE_EN
  logic             fail_valid;
  logic [4:0]       fail_idx;
  logic [31:0]      fail_exp;
  logic [31:0]      fail_act;
`endif

  // Wrapper side
  modport master (
    output start, rwe, rd, rs1_cpu, regA, exp_data,
    input  rs1_out, exp_addr, test_mode, busy, done, pass,
           err_count, write_count, cycle_count
`ifdef FAIL_CAPTURE_EN
    , input fail_valid, fail_idx, fail_exp, fail_act
`endif
  );

  // Checker side
  modport slave (
    input  start, rwe, rd, rs1_cpu, regA, exp_data,
    output rs1_out, exp_addr, test_mode, busy, done, pass,
           err_count, write_count, cycle_count
`ifdef FAIL_CAPTURE_EN
    , output fail_valid, fail_idx, fail_exp, fail_act
`endif
  );
endinterface

// File: rtl/reg_scan_checker.sv
// End-of-run checker: runs the CPU for NUM_CYCLES, counts regfile writes, then scans all 32 registers
// against an expected-value memory. Optional first-mismatch capture under FAIL_CAPTURE_EN.
module reg_scan_checker #(
  parameter int unsigned NUM_CYCLES = 255,
  parameter int unsigned CYC_W      = 10
) (
  input logic               clock,
  input logic               reset,
  reg_scan_checker_if.slave bus
);

  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'((NUM_CYCLES > 0) ? NUM_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, RUN, SCAN, DONE} state_t;

  state_t           state, state_next;
  logic [5:0]       issue_cnt;
  logic [4:0]       idx_q;
  logic [31:0]      rega_q;
  logic             cmp_vld;
  logic             test_mode, busy, done, pass;
  logic [5:0]       err_count;
  logic [15:0]      write_count;
  logic [CYC_W-1:0] cycle_count;
  logic             start_ok_c, mismatch_c, last_cmp_c;

  assign start_ok_c = bus.start && ((state == IDLE) || (state == DONE));
  assign mismatch_c = cmp_vld && (rega_q != bus.exp_data);
  assign last_cmp_c = cmp_vld && (idx_q == 5'd31);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start_ok_c) state_next = (NUM_CYCLES == 0) ? SCAN : RUN;
      RUN:        if (cycle_count == LAST_CYC) state_next = SCAN;
      SCAN:       if (last_cmp_c) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Port A is handed to the scan only while scanning
  assign bus.rs1_out     = (state == SCAN) ? issue_cnt[4:0] : bus.rs1_cpu;
  assign bus.exp_addr    = issue_cnt[4:0];
  assign bus.test_mode   = test_mode;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.pass        = pass;
  assign bus.err_count   = err_count;
  assign bus.write_count = write_count;
  assign bus.cycle_count = cycle_count;

  // Counters, scan pipeline and status flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      test_mode   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= 6'd0;
      write_count <= 16'd0;
      cycle_count <= '0;
      issue_cnt   <= 6'd0;
      idx_q       <= 5'd0;
      rega_q      <= 32'd0;
      cmp_vld     <= 1'b0;
    end else begin
      test_mode <= (state_next == SCAN);
      busy      <= (state_next == RUN) || (state_next == SCAN);
      done      <= (state_next == DONE);
      if (start_ok_c) begin
        pass        <= 1'b0;
        err_count   <= 6'd0;
        write_count <= 16'd0;
        cycle_count <= '0;
        issue_cnt   <= 6'd0;
        cmp_vld     <= 1'b0;
      end else if (state == RUN) begin
        cycle_count <= cycle_count + CYC_W'(1);
        if (bus.rwe && (bus.rd != 5'd0) && (write_count != 16'hFFFF))
          write_count <= write_count + 16'd1;
      end else if (state == SCAN) begin
        // Issue stage stops once all 32 indices have gone out
        if (!issue_cnt[5]) begin
          rega_q    <= bus.regA;
          idx_q     <= issue_cnt[4:0];
          issue_cnt <= issue_cnt + 6'd1;
          cmp_vld   <= 1'b1;
        end else begin
          cmp_vld   <= 1'b0;
        end
        if (mismatch_c) err_count <= err_count + 6'd1;
        if (last_cmp_c) pass <= (err_count == 6'd0) && !mismatch_c;
      end
    end
  end

`ifdef FAIL_CAPTURE_EN
  logic        fail_valid;
  logic [4:0]  fail_idx;
  logic [31:0] fail_exp, fail_act;

  assign bus.fail_valid = fail_valid;
  assign bus.fail_idx   = fail_idx;
  assign bus.fail_exp   = fail_exp;
  assign bus.fail_act   = fail_act;

  // Keep only the first mismatch of a run
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fail_valid <= 1'b0;
      fail_idx   <= 5'd0;
      fail_exp   <= 32'd0;
      fail_act   <= 32'd0;
    end else if (start_ok_c) begin
      fail_valid <= 1'b0;
      fail_idx   <= 5'd0;
      fail_exp   <= 32'd0;
      fail_act   <= 32'd0;
    end else if ((state == SCAN) && mismatch_c && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_idx   <= idx_q;
      fail_exp   <= bus.exp_data;
      fail_act   <= rega_q;
    end
  end
`endif

endmodule

// File: tb/tb_reg_scan_checker.sv
// Directed bench for reg_scan_checker: one instance with a 10-cycle run, one with a zero-length run,
// sharing a behavioural regfile and expected-value memory.
module tb_reg_scan_checker;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  reg_scan_checker_if #(.CYC_W(10)) bus_a ();
  reg_scan_checker_if #(.CYC_W(10)) bus_b ();

  reg_scan_checker #(.NUM_CYCLES(10), .CYC_W(10)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  reg_scan_checker #(.NUM_CYCLES(0),  .CYC_W(10)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  logic [31:0] regfile [32];
  logic [31:0] expmem  [32];
  logic [31:0] exp_q_a, exp_q_b;

  // Combinational regfile port A, one-cycle expected memory
  assign bus_a.regA = regfile[bus_a.rs1_out];
  assign bus_b.regA = regfile[bus_b.rs1_out];
  always_ff @(posedge clock) begin
    exp_q_a <= expmem[bus_a.exp_addr];
    exp_q_b <= expmem[bus_b.exp_addr];
  end
  assign bus_a.exp_data = exp_q_a;
  assign bus_b.exp_data = exp_q_b;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Pulse start on one instance; returns at the negedge after E0
  task automatic pulse(input bit sel_b);
    if (sel_b) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, inout int lat);
    while (!(sel_b ? bus_b.done : bus_a.done) && lat < 200) begin
      step();
      lat++;
    end
  endtask

  int lat;

  initial begin
    bus_a.start = 1'b0; bus_a.rwe = 1'b0; bus_a.rd = 5'd0; bus_a.rs1_cpu = 5'd7;
    bus_b.start = 1'b0; bus_b.rwe = 1'b0; bus_b.rd = 5'd0; bus_b.rs1_cpu = 5'd7;
    for (int i = 0; i < 32; i++) begin
      regfile[i] = 32'd0;
      expmem[i]  = 32'd0;
    end
    regfile[1] = 32'd5;
    expmem[1]  = 32'd5;

    // Reset state
    #12;
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_done", 32'(bus_a.done), 32'd0);
    check("rst_rs1_out", 32'(bus_a.rs1_out), 32'd7);
    check("rst_exp_addr", 32'(bus_a.exp_addr), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Matching memory, writes counted only for rd!=0
    pulse(1'b0);
    lat = 0;
    while (!bus_a.done && lat < 200) begin
      bus_a.rwe = (lat < 6);
      bus_a.rd  = (lat < 4) ? 5'd3 : 5'd0;
      step();
      lat++;
      if (lat == 5) begin
        check("run_busy", 32'(bus_a.busy), 32'd1);
        check("run_test_mode", 32'(bus_a.test_mode), 32'd0);
        check("run_rs1_out", 32'(bus_a.rs1_out), 32'd7);
      end
      if (lat == 12) begin
        check("scan_test_mode", 32'(bus_a.test_mode), 32'd1);
        check("scan_rs1_out", 32'(bus_a.rs1_out), 32'd2);
      end
    end
    bus_a.rwe = 1'b0;
    check("t1_latency", 32'(lat), 32'd43);
    check("t1_pass", 32'(bus_a.pass), 32'd1);
    check("t1_err", 32'(bus_a.err_count), 32'd0);
    check("t1_cycles", 32'(bus_a.cycle_count), 32'd10);
    check("t1_writes", 32'(bus_a.write_count), 32'd4);
    check("t1_busy", 32'(bus_a.busy), 32'd0);

    // Single mismatch at r31
    regfile[7] = 32'd9;  expmem[7] = 32'd9;
    regfile[31] = 32'hFFFF_FFFF;
    pulse(1'b0);
    lat = 0;
    wait_done(1'b0, lat);
    check("t2_latency", 32'(lat), 32'd43);
    check("t2_err", 32'(bus_a.err_count), 32'd1);
    check("t2_pass", 32'(bus_a.pass), 32'd0);
`ifdef FAIL_CAPTURE_EN
    check("t2_fail_valid", 32'(bus_a.fail_valid), 32'd1);
    check("t2_fail_idx", 32'(bus_a.fail_idx), 32'd31);
    check("t2_fail_exp", bus_a.fail_exp, 32'd0);
    check("t2_fail_act", bus_a.fail_act, 32'hFFFF_FFFF);
`endif

    // Three mismatches, then restart from DONE
    regfile[2] = 32'd1;
    regfile[3] = 32'd2;
    pulse(1'b0);
    lat = 0;
    wait_done(1'b0, lat);
    check("t3_err", 32'(bus_a.err_count), 32'd3);
`ifdef FAIL_CAPTURE_EN
    check("t3_fail_idx", 32'(bus_a.fail_idx), 32'd2);
    check("t3_fail_act", bus_a.fail_act, 32'd1);
`endif
    pulse(1'b0);
    check("t3_clr_err", 32'(bus_a.err_count), 32'd0);
    check("t3_clr_writes", 32'(bus_a.write_count), 32'd0);
    check("t3_clr_cycles", 32'(bus_a.cycle_count), 32'd0);
    check("t3_clr_done", 32'(bus_a.done), 32'd0);
    check("t3_clr_busy", 32'(bus_a.busy), 32'd1);
    lat = 0;
    wait_done(1'b0, lat);
    check("t3_rerun_latency", 32'(lat), 32'd43);
    check("t3_rerun_err", 32'(bus_a.err_count), 32'd3);
    check("t3_rerun_pass", 32'(bus_a.pass), 32'd0);

    // Zero-length run, start ignored while busy
    pulse(1'b1);
    check("t4_scan_entry", 32'(bus_b.test_mode), 32'd1);
    lat = 0;
    while (!bus_b.done && lat < 200) begin
      bus_b.start = (lat == 5);
      step();
      lat++;
    end
    bus_b.start = 1'b0;
    check("t4_latency", 32'(lat), 32'd33);
    check("t4_err", 32'(bus_b.err_count), 32'd3);
    check("t4_cycles", 32'(bus_b.cycle_count), 32'd0);

    // Asynchronous reset mid-scan at scan_idx 12
    pulse(1'b0);
    lat = 0;
    while (lat < 22) begin
      step();
      lat++;
    end
    check("t5_pre_rs1_out", 32'(bus_a.rs1_out), 32'd12);
    reset = 1'b1;
    #1;
    check("t5_busy", 32'(bus_a.busy), 32'd0);
    check("t5_test_mode", 32'(bus_a.test_mode), 32'd0);
    check("t5_rs1_out", 32'(bus_a.rs1_out), 32'd7);
    check("t5_exp_addr", 32'(bus_a.exp_addr), 32'd0);
    check("t5_err", 32'(bus_a.err_count), 32'd0);
    check("t5_cycles", 32'(bus_a.cycle_count), 32'd0);
    check("t5_pass", 32'(bus_a.pass), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_scan_checker.md
# reg_scan_checker

Synthesizable end-of-run checker for the pipelined CPU test wrapper. After a start pulse it lets the processor run a fixed number of cycles while counting register-file writes. It then takes over the regfile read port A, scans all 32 registers and compares each against an expected-value memory. It reports an error count and a pass/done flag, so regression runs on FPGA need no simulator file I/O.

## Interface
Parameters:
- NUM_CYCLES, 255, processor run length in clock cycles before the scan (0 allowed)
- CYC_W, 10, width of the cycle counter; NUM_CYCLES < 2^CYC_W

Ports:
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  in  1  one-cycle pulse to begin a run; honoured only in IDLE or DONE
- rwe  in  1  regfile write enable from the processor
- rd  in  5  regfile write register from the processor
- rs1_cpu  in  5  processor's read-port-A register select
- rs1_out  out  5  select driven to regfile port A: scan_idx in SCAN, else rs1_cpu
- regA  in  32  regfile port-A read data (combinational from rs1_out)
- exp_addr  out  5  expected-value memory address
- exp_data  in  32  expected-value memory data, valid one cycle after exp_addr
- test_mode  out  1  high while in SCAN
- busy  out  1  high in RUN or SCAN
- done  out  1  high in DONE
- pass  out  1  done && err_count==0
- err_count  out  6  mismatching registers, 0..32
- write_count  out  16  writes observed in RUN with rd!=0, saturating at 16'hFFFF
- cycle_count  out  CYC_W  cycles elapsed in RUN

## Operation
- States: IDLE, RUN, SCAN, DONE.
- Reset values: state IDLE; rs1_out = rs1_cpu; exp_addr 0; test_mode, busy, done, pass 0; all counters 0.
- IDLE/DONE + start:
  - Clear err_count, write_count and cycle_count; scan_idx = 0.
  - Go to RUN, or straight to SCAN if NUM_CYCLES==0.
- RUN:
  - Each rising edge: cycle_count++.
  - If rwe && rd!=0, write_count++ (saturating).
  - rd==0 writes are ignored.
  - Leave for SCAN on the edge where cycle_count reaches NUM_CYCLES-1 → NUM_CYCLES.
- SCAN is a two-stage pipeline:
  - Issue stage: rs1_out = exp_addr = scan_idx. Each edge captures regA into regA_q and the index into idx_q, then scan_idx++ for issue counts 0..31.
  - Compare stage: one cycle later, compare regA_q with exp_data; on mismatch, err_count++.
  - Register 0 is compared like any other; expected memory must hold 0.
  - After the compare of index 31, go to DONE.
- DONE: hold all results until start or reset. start in DONE restarts identically to IDLE.
- start while busy: ignored; counters unaffected.
- Writes during SCAN are not counted. The processor keeps running, and test_mode tells the wrapper to block its port-A use.
- Reset mid-operation: immediate return to IDLE with all reset values; no partial results are retained.

## Timing
- Edge E0 samples start. RUN occupies the N = NUM_CYCLES cycles after E0; edges E1..EN sample writes.
- SCAN is entered after edge EN (after E0 if N==0).
- Issue cycles run from EN+1 to EN+32. Compares happen at edges E(N+2)..E(N+33).
- done, pass and final err_count are visible after edge E(N+33). Total latency from start to done is N+33 cycles.
- rs1_out switches combinationally with state; the switch to scan_idx is glitch-free only relative to clock edges.
- exp_data latency is exactly 1 cycle; no back-pressure.

## Configuration
- FAIL_CAPTURE_EN defined:
  - Adds outputs fail_valid (1), fail_idx (5), fail_exp (32) and fail_act (32), all reset to 0 and cleared on start.
  - On the first mismatch of a run, the block latches index, expected and actual values and sets fail_valid. Later mismatches do not overwrite them.
- FAIL_CAPTURE_EN undefined: these ports and registers do not exist; all other behaviour is identical.

## Test plan
- NUM_CYCLES=10; expected memory matches regfile (r1=5, others 0); pulse start → done after 43 cycles, pass=1, err_count=0, cycle_count=10.
- During RUN, drive rwe=1 with rd=3 for 4 cycles and rd=0 for 2 cycles → write_count=4.
- Regfile r7=9 and r31=-1, expected memory r7=9 and r31=0 → err_count=1, pass=0. With FAIL_CAPTURE_EN: fail_idx=31, fail_exp=0, fail_act=32'hFFFFFFFF.
- NUM_CYCLES=0 → SCAN entered the cycle after start and done after 33 cycles. start pulsed again while busy → ignored, done timing unchanged.
- Assert reset asynchronously mid-SCAN (scan_idx=12) → all outputs at reset values immediately, rs1_out follows rs1_cpu.
- From DONE with err_count=3, pulse start → counters clear the next cycle and a full run repeats with identical results.
